// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART send path.
package uart_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE      = 2'd0;
  localparam tx_state_t ST_WAIT_BUSY = 2'd1;
  localparam tx_state_t ST_WAIT_DONE = 2'd2;

  localparam int MODE_STREAM = 0;
  localparam int MODE_BATCH  = 1;

  localparam logic [7:0] TERM_DEFAULT = 8'h0D;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/uart_send_queue_if.sv
// Producer/transmitter-facing signal bundle of uart_send_queue.
interface uart_send_queue_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH*DATA_W-1:0] src_data;
  logic [NUM_CH-1:0]        src_valid;
  logic                     flush;
  logic                     tx_busy;
  logic [DATA_W-1:0]        tx_data;
  logic                     tx_start;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     empty;
  logic [7:0]               drop_cnt;

  modport master (
    output src_data, src_valid, flush, tx_busy,
    input  tx_data, tx_start, count, full, empty, drop_cnt
  );

  modport slave (
    input  src_data, src_valid, flush, tx_busy,
    output tx_data, tx_start, count, full, empty, drop_cnt
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and same-cycle push+pop.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_r;
  logic              empty_r;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic [CNT_W-1:0]  count_next_s;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    pop_ok_s     = pop && !empty_r;
    push_ok_s    = push && (!full_r || pop_ok_s);
    count_next_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= push_ok_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r <= pop_ok_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      count_r  <= count_next_s;
      full_r   <= (count_next_s == CNT_W'(DEPTH));
      empty_r  <= (count_next_s == '0);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;
endmodule

// File: rtl/uart_send_queue.sv
// Multi-source byte queue feeding the uart transmitter: fixed-priority
// arbitration, drop accounting, optional batch release and a drain FSM.
module uart_send_queue
  import uart_pkg::*;
#(
  parameter int               DATA_W   = 8,
  parameter int               DEPTH    = 16,
  parameter int               NUM_CH   = 2,
  parameter int               MODE     = MODE_STREAM,
  parameter logic [DATA_W-1:0] TERM    = DATA_W'(TERM_DEFAULT),
  parameter int               BUSY_TMO = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_send_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PC_W  = $clog2(NUM_CH + 1);
  localparam int TMO_W = $clog2(BUSY_TMO + 1);

  logic [DATA_W-1:0] cand_data_s;
  logic              any_valid_s;
  logic [PC_W-1:0]   req_cnt_s;
  logic [PC_W-1:0]   drops_s;
  logic              push_s;
  logic              pop_s;
  logic              eligible_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  count_next_s;
  logic              full_s;
  logic              empty_s;
  logic [DATA_W-1:0] head_s;

  tx_state_t         state_r;
  logic [TMO_W-1:0]  timer_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              tx_start_r;
  logic [CNT_W-1:0]  rel_cnt_r;
  logic [7:0]        drop_cnt_r;

  // Scan from the top channel down so the lowest asserting index wins.
  always_comb begin
    cand_data_s = '0;
    any_valid_s = 1'b0;
    req_cnt_s   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand_data_s = bus.src_valid[i] ? bus.src_data[i*DATA_W +: DATA_W] : cand_data_s;
      any_valid_s = any_valid_s | bus.src_valid[i];
      req_cnt_s   = req_cnt_s + PC_W'(bus.src_valid[i]);
    end
  end

  // Pop/push decisions; released bytes are always the oldest ones.
  always_comb begin
    eligible_s   = (MODE == MODE_STREAM) ? 1'b1 : (rel_cnt_r != '0);
    pop_s        = (state_r == ST_IDLE) && !empty_s && eligible_s && !bus.tx_busy;
    push_s       = any_valid_s && (!full_s || pop_s);
    drops_s      = req_cnt_s - PC_W'(push_s);
    count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (cand_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Saturating dropped-request counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'd0;
    end else begin
      drop_cnt_r <= sat_add8(drop_cnt_r, 8'(drops_s));
    end
  end

  // Batch release: flush or an accepted terminator releases everything queued.
  always_ff @(posedge clk) begin
    if (!rst_n || (MODE == MODE_STREAM)) begin
      rel_cnt_r <= '0;
    end else if (bus.flush || (push_s && (cand_data_s == TERM))) begin
      rel_cnt_r <= count_next_s;
    end else if (pop_s) begin
      rel_cnt_r <= rel_cnt_r - CNT_W'(1);
    end else begin
      rel_cnt_r <= rel_cnt_r;
    end
  end

  // Drain FSM; a transmitter that never raises busy is timed out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      timer_r    <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            tx_data_r  <= head_s;
            tx_start_r <= 1'b1;
            timer_r    <= '0;
            state_r    <= ST_WAIT_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_r <= ST_WAIT_DONE;
          end else if (timer_r == TMO_W'(BUSY_TMO - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TMO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;
  assign bus.count    = count_s;
  assign bus.full     = full_s;
  assign bus.empty    = empty_s;
  assign bus.drop_cnt = drop_cnt_r;
endmodule

// File: doc/uart_send_queue.md
Name: uart_send_queue

Overview:
- Buffered, multi-source byte sender placed between input producers and the `uart` transmitter.
- Producers are the switch/button pulser path and the `ps2_keyboard` key_valid path, generalised to NUM_CH sources.
- Replaces the single-register, fire-and-forget send path. Adds:
  - a FIFO of DEPTH bytes;
  - fixed-priority arbitration;
  - drop accounting;
  - a batch mode that holds bytes until a flush or a terminator byte.

Parameters:
- DATA_W, 8, byte width of every source and of the transmitter.
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- NUM_CH, 2, number of producer channels; channel 0 has highest priority.
- MODE, 0, 0 = stream (send as soon as possible), 1 = batch (send only released bytes).
- TERM, 8'h0D, terminator byte that auto-releases in batch mode.
- BUSY_TMO, 4, cycles to wait for tx_busy to rise after tx_start before treating the byte as sent.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- src_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- src_valid  in  NUM_CH  one-cycle push request per channel
- flush  in  1  one-cycle pulse; releases all queued bytes (batch mode)
- tx_busy  in  1  transmitter busy
- tx_data  out  DATA_W  byte presented to the transmitter; registered
- tx_start  out  1  one-cycle send strobe
- count  out  $clog2(DEPTH+1)  bytes currently queued
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- drop_cnt  out  8  dropped-byte counter, saturates at 255

Behaviour:
- Reset (rst_n low at posedge clk) clears the following:
  - rd/wr pointers and count to 0, so empty=1 and full=0;
  - tx_data to 0, tx_start to 0, drop_cnt to 0;
  - rel_cnt to 0, FSM to IDLE.
- Reset mid-transfer abandons FSM tracking; the transmitter finishes its byte on its own.
- Arbitration:
  - Each cycle the lowest-index channel with src_valid=1 is the push candidate.
  - All other asserting channels are dropped.
- Push rules:
  - The candidate is written if count<DEPTH, or if a pop occurs in the same cycle (full + simultaneous pop = accept).
  - Otherwise the candidate is dropped.
- Drop accounting: drop_cnt += number of dropped requests this cycle, saturating at 255.
- count is updated as count + push - pop.
- Pointers wrap modulo DEPTH.
- Release logic, MODE=0: every queued byte is eligible to send.
- Release logic, MODE=1:
  - rel_cnt holds the number of eligible bytes.
  - On flush=1, or when an accepted push equals TERM: rel_cnt <= count_next (all bytes, including the one pushed this cycle).
  - Otherwise, each pop decrements rel_cnt.
  - Flush while empty has no effect (rel_cnt stays 0).
- Drain FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !empty, the byte is eligible, and tx_busy=0, then pop the head into tx_data, pulse tx_start for exactly 1 cycle, clear the timer, and go to WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1, go to WAIT_DONE. If the timer reaches BUSY_TMO-1 with no busy, go to IDLE.
  - WAIT_DONE: on tx_busy=0, go to IDLE.
- Latency: a byte pushed into an empty, released queue with tx_busy=0 produces tx_start 2 cycles after the src_valid cycle (one cycle to write, one cycle to pop).
- Minimum byte spacing is 3 cycles.
- tx_data holds its value until the next pop.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef (IDLE/WAIT_BUSY/WAIT_DONE);
  - MODE_STREAM / MODE_BATCH constants;
  - default TERM constant.
- One sub-module, sync_fifo (DATA_W, DEPTH): storage, pointers, count/full/empty, and simultaneous push/pop.
- Arbitration, drop accounting, release logic and the FSM stay in uart_send_queue.

Test Plan:
- Stream mode; push 8'hA5 on ch0; tx_busy model rises 1 cycle after tx_start and is held 10 cycles → tx_start 2 cycles later with tx_data=8'hA5; count back to 0; next byte not started until busy falls.
- Simultaneous ch0=8'h11 and ch1=8'h22 → only 8'h11 queued; drop_cnt=1.
- Fill DEPTH=16 with busy held high, then push a 17th byte → full=1, drop_cnt increments. Next cycle, push again while the FSM pops (busy released) → accepted; count stays 16.
- Batch mode: push 8'h41, 8'h42 → no tx_start. Then push TERM 8'h0D → 3 bytes sent in order 41, 42, 0D. Push 8'h43 → held until a flush pulse, then sent.
- tx_busy never rises after tx_start → FSM returns to IDLE after BUSY_TMO=4 cycles and sends the next byte.
- Drop saturation, then rst_n=0 for 1 cycle while in WAIT_DONE:
  - force 300 drops → drop_cnt=255;
  - after reset: count=0, drop_cnt=0, tx_start=0, FSM in IDLE.
